uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART Tx arbiter: FSM state encoding and default character width.
package uart_pkg;

  localparam int UART_DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } uart_tx_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping to 0.
module uart_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int w_k;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[w_k]) begin
        any_o        = 1'b1;
        grant_o[w_k] = 1'b1;
        idx_o        = IDX_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART Tx channel among N_REQUESTERS with round-robin arbitration and a WAIT timeout.
// Optional UART_TX_ARB_LOCK_EN: multi-character packets hold the grant until req_last_i.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQUESTERS      = 4,
  parameter int MAX_UART_DATA_W   = UART_DATA_W_DEFAULT,
  parameter int TX_TIMEOUT_CYCLES = 1000000
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [N_REQUESTERS-1:0]                 req_valid_i,
  input  logic [N_REQUESTERS*MAX_UART_DATA_W-1:0] req_data_i,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQUESTERS-1:0]                 req_last_i,
`endif
  output logic [N_REQUESTERS-1:0]                 req_ready_o,
  output logic                                    tx_start_o,
  output logic [MAX_UART_DATA_W-1:0]              tx_data_o,
  input  logic                                    tx_done_i,
  output logic [$clog2(N_REQUESTERS)-1:0]         grant_id_o,
  output logic                                    busy_o,
  output logic                                    timeout_o
);

  localparam int IDX_W = $clog2(N_REQUESTERS);
  localparam int CNT_W = $clog2(TX_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT_CYCLES - 1);

  uart_tx_state_e             r_state;
  logic [IDX_W-1:0]           r_ptr;
  logic [IDX_W-1:0]           r_grant_id;
  logic [MAX_UART_DATA_W-1:0] r_tx_data;
  logic                       r_tx_start;
  logic                       r_timeout;
  logic [CNT_W-1:0]           r_cnt;

  logic [N_REQUESTERS-1:0]    w_req;
  logic [N_REQUESTERS-1:0]    w_grant;
  logic [IDX_W-1:0]           w_idx;
  logic [IDX_W-1:0]           w_ptr_nxt;
  logic                       w_any;

`ifdef UART_TX_ARB_LOCK_EN
  logic                       r_lock;
  logic [IDX_W-1:0]           r_lock_id;

  // While a packet is open only its owner may compete.
  assign w_req = r_lock ? (req_valid_i & (N_REQUESTERS'(1) << r_lock_id)) : req_valid_i;
`else
  assign w_req = req_valid_i;
`endif

  uart_rr_arbiter #(
    .N     (N_REQUESTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (w_req),
    .ptr_i   (r_ptr),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  assign w_ptr_nxt = (w_idx == IDX_W'(N_REQUESTERS - 1)) ? '0 : IDX_W'(w_idx + 1'b1);

  assign req_ready_o = (r_state == IDLE && !rst_i) ? w_grant : '0;
  assign tx_start_o  = r_tx_start;
  assign tx_data_o   = r_tx_data;
  assign grant_id_o  = r_grant_id;
  assign busy_o      = (r_state != IDLE);
  assign timeout_o   = r_timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      r_cnt      <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      r_lock     <= 1'b0;
      r_lock_id  <= '0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_tx_data  <= req_data_i[int'(w_idx)*MAX_UART_DATA_W +: MAX_UART_DATA_W];
            r_grant_id <= w_idx;
            r_tx_start <= 1'b1;
            r_state    <= START;
`ifdef UART_TX_ARB_LOCK_EN
            if (req_last_i[w_idx]) begin
              r_lock <= 1'b0;
              r_ptr  <= w_ptr_nxt;
            end else begin
              r_lock    <= 1'b1;
              r_lock_id <= w_idx;
            end
`else
            r_ptr      <= w_ptr_nxt;
`endif
          end
        end
        START: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // Done wins over a timeout landing in the same cycle.
          if (tx_done_i) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            r_lock    <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected (id, data) per start,
// a negedge monitor pops and compares on every tx_start_o.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  req_last = '1;
  logic          tx_done = 1'b0;
  logic [N-1:0]  req_ready_o;
  logic          tx_start_o;
  logic [W-1:0]  tx_data_o;
  logic [1:0]    grant_id_o;
  logic          busy_o;
  logic          timeout_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQUESTERS      (N),
    .MAX_UART_DATA_W   (W),
    .TX_TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_last_i  (req_last),
`endif
    .req_ready_o (req_ready_o),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
    .tx_done_i   (tx_done),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic prev_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got id=%0d data=0x%0h, nothing queued", grant_id_o, tx_data_o);
      end else begin
        mon_e = sb.pop_front();
        chk("start_grant_id", 32'(grant_id_o), 32'(mon_e.id));
        chk("start_tx_data", 32'(tx_data_o), 32'(mon_e.data));
      end
      chk("start_single_cycle", 32'(prev_start), 32'd0);
    end
    prev_start <= tx_start_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [7:0] d);
    req_data[k*W +: W] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_start", 32'(tx_start_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_grant_id", 32'(grant_id_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  // Called in an IDLE cycle (just after the edge); ends just after the accepting edge.
  task automatic accept(input int id, input logic [7:0] d, input bit drop);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    sb.push_back(e);
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("ready_onehot", 32'(req_ready_o), 32'(1) << id);
    tick();
    if (drop) req_valid = '0;
  endtask

  // Called in the START cycle; pulses tx_done d cycles after the start.
  task automatic finish(input int d, input logic [7:0] d_exp);
    @(negedge clk);
    chk("start_busy", 32'(busy_o), 32'd1);
    chk("start_ready_zero", 32'(req_ready_o), 32'd0);
    repeat (d) tick();
    chk("data_held", 32'(tx_data_o), 32'(d_exp));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  int tmo_seen;

  initial begin
    // Reset holds ready low even with a request pending; then single transfer.
    req_valid = 4'b0001;
    set_data(0, 8'h55);
    tick();
    do_reset();
    accept(0, 8'h55, 1'b1);
    finish(20, 8'h55);
    @(negedge clk);
    chk("after_done_busy", 32'(busy_o), 32'd0);
    tick();

    // All four continuously valid: order 0,1,2,3,0.
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) set_data(k, 8'hA0 + 8'(k));
    do_reset();
    for (int i = 0; i < 5; i++) begin
      accept(i % N, 8'hA0 + 8'(i % N), i == 4);
      finish(5, 8'hA0 + 8'(i % N));
    end

    // Timeout: no done, pulse exactly TO cycles after entering WAIT; next request accepted.
    req_valid = 4'b0100;
    set_data(2, 8'h3C);
    accept(2, 8'h3C, 1'b1);
    tick();
    repeat (TO - 1) tick();
    chk("pre_timeout_pulse", 32'(timeout_o), 32'd0);
    chk("pre_timeout_busy", 32'(busy_o), 32'd1);
    req_valid = 4'b1000;
    set_data(3, 8'h7E);
    tick();
    chk("timeout_pulse", 32'(timeout_o), 32'd1);
    chk("timeout_idle", 32'(busy_o), 32'd0);
    accept(3, 8'h7E, 1'b1);
    chk("timeout_one_cycle", 32'(timeout_o), 32'd0);
    finish(3, 8'h7E);

    // Done in the same cycle the counter hits the limit: no timeout.
    req_valid = 4'b0001;
    set_data(0, 8'h11);
    accept(0, 8'h11, 1'b1);
    tick();
    repeat (TO - 1) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("done_at_limit_no_timeout", 32'(timeout_o), 32'd0);
    chk("done_at_limit_idle", 32'(busy_o), 32'd0);
    tick();
    chk("done_at_limit_later", 32'(timeout_o), 32'd0);
    // tx_done in IDLE is ignored.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_done_busy", 32'(busy_o), 32'd0);
    chk("idle_done_start", 32'(tx_start_o), 32'd0);

    // Reset in WAIT abandons the character, no timeout afterwards.
    req_valid = 4'b0010;
    set_data(1, 8'h22);
    accept(1, 8'h22, 1'b1);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wait_rst_busy", 32'(busy_o), 32'd0);
    chk("wait_rst_data", 32'(tx_data_o), 32'd0);
    chk("wait_rst_grant", 32'(grant_id_o), 32'd0);
    chk("wait_rst_start", 32'(tx_start_o), 32'd0);
    chk("wait_rst_timeout", 32'(timeout_o), 32'd0);
    tmo_seen = 0;
    repeat (TO + 10) begin
      tick();
      if (timeout_o) tmo_seen++;
    end
    chk("wait_rst_no_late_timeout", 32'(tmo_seen), 32'd0);

`ifdef UART_TX_ARB_LOCK_EN
    // Packet lock: requester 2 sends three chars (last=0,0,1) while 0 waits; 0 then wins via wrap.
    do_reset();
    req_last  = 4'b1111;
    req_valid = 4'b0010;
    set_data(1, 8'h01);
    accept(1, 8'h01, 1'b1);
    finish(2, 8'h01);
    req_valid = 4'b0101;
    set_data(0, 8'hD0);
    set_data(2, 8'hC0);
    req_last  = 4'b1011;
    accept(2, 8'hC0, 1'b0);
    set_data(2, 8'hC1);
    finish(2, 8'hC0);
    accept(2, 8'hC1, 1'b0);
    set_data(2, 8'hC2);
    req_last = 4'b1111;
    finish(2, 8'hC1);
    accept(2, 8'hC2, 1'b0);
    req_valid = 4'b0001;
    finish(2, 8'hC2);
    accept(0, 8'hD0, 1'b1);
    finish(2, 8'hD0);
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
